// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types for the UART receive-side controller.
//   rx_ctrl_state_t : receive-enable sequencer states
//   ERR_PARITY / ERR_FRAMING : bit positions inside the 2-bit error field
//   rx_fifo_entry_t : one FIFO word, {err[1:0], data[7:0]}
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    ARM   = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } rx_ctrl_state_t;

  localparam int ERR_PARITY  = 1;
  localparam int ERR_FRAMING = 0;

  typedef struct packed {
    logic [1:0] err;
    logic [7:0] data;
  } rx_fifo_entry_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Synchronous FIFO holding received characters with their error flags.
// Head entry is presented combinationally (no read latency); write latency 1.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, pop       write / read requests (qualified internally)
//   flush           empties the FIFO; wins over a same-cycle push and pop
//   wr_entry        entry to write
//   rd_entry        head entry
//   full, empty     occupancy flags
//   level           occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LVLW  = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  rx_fifo_entry_t   wr_entry,
  output rx_fifo_entry_t   rd_entry,
  output logic             full,
  output logic             empty,
  output logic [LVLW-1:0]  level
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [LVLW-1:0] level_reg;
  rx_fifo_entry_t  mem_reg [DEPTH];
  logic            do_push;
  logic            do_pop;

  assign full  = (level_reg == LVLW'(DEPTH));
  assign empty = (level_reg == '0);
  assign level = level_reg;

  // A push into a full FIFO is accepted only if a pop frees a slot the same cycle.
  assign do_push = push & ~flush & (~full | pop);
  assign do_pop  = pop & ~empty & ~flush;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : gen_mem
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          mem_reg[gi] <= '0;
        end else if (do_push && (wr_ptr_reg == AW'(gi))) begin
          mem_reg[gi] <= wr_entry;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (do_push && !do_pop)      level_reg <= level_reg + LVLW'(1);
      else if (!do_push && do_pop) level_reg <= level_reg - LVLW'(1);
    end
  end

  assign rd_entry = mem_reg[rd_ptr_reg];

endmodule

// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
// Receive-side controller between the oversampling UART receiver and the bus.
//   - sequences rx_enable (arm on one idle bit-time, graceful drain on disable)
//   - merges out-of-band parity/framing pulses into the matching character
//   - buffers characters in uart_rx_fifo with a valid/ready pop port
//   - overrun / idle-timeout / watermark status and a registered interrupt
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   enable, rx_en_cfg         global enable, software receive enable
//   flush                     single-cycle FIFO flush
//   osr_tick, osr_value       oversample tick, ticks per bit (0 treated as 1)
//   rxd_sync                  synchronised line, idle detection while arming
//   rx_data, rx_valid         character from receiver
//   rx_framing_error, rx_parity_error  error pulses from receiver
//   rx_busy                   receiver mid-character
//   rx_enable                 enable to receiver
//   m_data, m_err, m_valid, m_ready    FIFO pop port (head entry)
//   level, watermark          occupancy, level-interrupt threshold (0 = off)
//   overrun, timeout          sticky status, cleared by clr_overrun/clr_timeout
//   irq                       registered interrupt
// Optional build macro UART_RX_CTRL_ERR_DROP_EN: errored characters are
// discarded and flagged on a sticky err_drop output (cleared by clr_overrun).
// -----------------------------------------------------------------------------
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int TO_BITS = 40,
  parameter int LVLW    = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            rx_en_cfg,
  input  logic            flush,
  input  logic            osr_tick,
  input  logic [7:0]      osr_value,
  input  logic            rxd_sync,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  input  logic            rx_framing_error,
  input  logic            rx_parity_error,
  input  logic            rx_busy,
  output logic            rx_enable,
  output logic [7:0]      m_data,
  output logic [1:0]      m_err,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [LVLW-1:0] level,
  input  logic [LVLW-1:0] watermark,
  output logic            overrun,
  output logic            timeout,
  input  logic            clr_overrun,
  input  logic            clr_timeout,
`ifdef UART_RX_CTRL_ERR_DROP_EN
  output logic            err_drop,
`endif
  output logic            irq
);

  localparam int TOW = $clog2(TO_BITS + 1);

  rx_ctrl_state_t state_reg, state_next;
  logic [7:0]     bit_cnt_reg;
  logic [7:0]     arm_cnt_reg;
  logic [TOW-1:0] to_cnt_reg;
  logic [1:0]     pend_err_reg, pend_err_next;
  logic           overrun_reg, timeout_reg, irq_reg;

  logic [7:0]     osr_last;
  logic           bit_tick, arm_done;
  logic [1:0]     pulse_err, merged_err;
  logic           push_req, fifo_push, pop, irq_extra;
  logic           overrun_set, to_clear, to_hit, wm_hit;
  logic           fifo_full, fifo_empty;
  rx_fifo_entry_t wr_entry, rd_entry;

  // osr_value of 0 behaves as 1 tick per bit.
  assign osr_last = (osr_value == 8'd0) ? 8'd0 : (osr_value - 8'd1);

  // '>=' keeps the counter wrapping promptly if osr_value shrinks mid-count.
  assign bit_tick = osr_tick && (bit_cnt_reg >= osr_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           bit_cnt_reg <= '0;
    else if (osr_tick) bit_cnt_reg <= bit_tick ? 8'd0 : bit_cnt_reg + 8'd1;
  end

  // Idle-line qualification while arming: one full bit-time of 1s on osr ticks.
  assign arm_done = (state_reg == ARM) && rxd_sync && osr_tick && (arm_cnt_reg >= osr_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    arm_cnt_reg <= '0;
    else if (state_reg != ARM || !rxd_sync)     arm_cnt_reg <= '0;
    else if (osr_tick)                          arm_cnt_reg <= arm_cnt_reg + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= OFF;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      OFF:   if (enable && rx_en_cfg) state_next = ARM;
      ARM: begin
        if (!rx_en_cfg)    state_next = OFF;
        else if (arm_done) state_next = RUN;
      end
      RUN:   if (!rx_en_cfg) state_next = rx_busy ? DRAIN : OFF;
      DRAIN: if (!rx_busy || rx_valid) state_next = OFF;
      default: state_next = OFF;
    endcase
    if (!enable) state_next = OFF;
  end

  assign rx_enable = (state_reg == RUN) || (state_reg == DRAIN);
  assign push_req  = rx_valid && rx_enable;
  assign pop       = m_valid && m_ready;

  // Error pulses arrive out of band; hold them until the character strobe.
  always_comb begin
    pulse_err              = 2'b00;
    pulse_err[ERR_PARITY]  = rx_parity_error;
    pulse_err[ERR_FRAMING] = rx_framing_error;
  end
  assign merged_err = pend_err_reg | pulse_err;

  always_comb begin
    pend_err_next = merged_err;
    if (flush || state_next == OFF || rx_valid) pend_err_next = 2'b00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_err_reg <= 2'b00;
    else     pend_err_reg <= pend_err_next;
  end

`ifdef UART_RX_CTRL_ERR_DROP_EN
  logic err_drop_reg;
  assign fifo_push = push_req && (merged_err == 2'b00);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_drop_reg <= 1'b0;
    else     err_drop_reg <= (push_req && (merged_err != 2'b00) && !flush)
                             | (err_drop_reg & ~clr_overrun);
  end
  assign err_drop  = err_drop_reg;
  assign irq_extra = err_drop_reg;
`else
  assign fifo_push = push_req;
  assign irq_extra = 1'b0;
`endif

  assign wr_entry.err  = merged_err;
  assign wr_entry.data = rx_data;

  uart_rx_fifo #(
    .DEPTH (DEPTH),
    .LVLW  (LVLW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .pop      (pop),
    .flush    (flush),
    .wr_entry (wr_entry),
    .rd_entry (rd_entry),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (level)
  );

  assign m_valid = ~fifo_empty;
  assign m_data  = rd_entry.data;
  assign m_err   = rd_entry.err;

  // Flush discards the character silently, so it never counts as overrun.
  assign overrun_set = fifo_push && fifo_full && !pop && !flush;

  // Idle timeout: bit-times elapsed with data waiting and no FIFO traffic.
  assign to_clear = push_req || pop || flush || (level == '0);
  assign to_hit   = !to_clear && bit_tick && (to_cnt_reg == TOW'(TO_BITS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                              to_cnt_reg <= '0;
    else if (to_clear)                                    to_cnt_reg <= '0;
    else if (bit_tick && to_cnt_reg != TOW'(TO_BITS))     to_cnt_reg <= to_cnt_reg + TOW'(1);
  end

  assign wm_hit = (watermark != '0) && (level >= watermark);

  // Set beats clear on the same cycle for the sticky bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_reg <= 1'b0;
      timeout_reg <= 1'b0;
      irq_reg     <= 1'b0;
    end else begin
      overrun_reg <= overrun_set | (overrun_reg & ~clr_overrun);
      timeout_reg <= to_hit | (timeout_reg & ~clr_timeout);
      irq_reg     <= overrun_reg | timeout_reg | wm_hit | irq_extra;
    end
  end

  assign overrun = overrun_reg;
  assign timeout = timeout_reg;
  assign irq     = irq_reg;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_ctrl
// Scoreboard bench: each stimulus cycle updates a queue-based reference model
// of the FIFO and status bits; a negedge monitor compares status every cycle
// and pops/compares the expected entry whenever the DUT delivers a character.
// -----------------------------------------------------------------------------
module tb_uart_rx_ctrl;
  import uart_pkg::*;

  localparam int DEPTH   = 16;
  localparam int TO_BITS = 40;
  localparam int LVLW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst, enable, rx_en_cfg, flush, osr_tick, rxd_sync;
  logic [7:0]      osr_value, rx_data, m_data;
  logic            rx_valid, rx_framing_error, rx_parity_error, rx_busy, rx_enable;
  logic [1:0]      m_err;
  logic            m_valid, m_ready, overrun, timeout, clr_overrun, clr_timeout, irq;
  logic [LVLW-1:0] level, watermark;
`ifdef UART_RX_CTRL_ERR_DROP_EN
  logic            err_drop;
`endif

  always #5 clk = ~clk;

  uart_rx_ctrl #(.DEPTH(DEPTH), .TO_BITS(TO_BITS), .LVLW(LVLW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .rx_en_cfg(rx_en_cfg), .flush(flush),
    .osr_tick(osr_tick), .osr_value(osr_value), .rxd_sync(rxd_sync),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_framing_error(rx_framing_error),
    .rx_parity_error(rx_parity_error), .rx_busy(rx_busy), .rx_enable(rx_enable),
    .m_data(m_data), .m_err(m_err), .m_valid(m_valid), .m_ready(m_ready),
    .level(level), .watermark(watermark), .overrun(overrun), .timeout(timeout),
    .clr_overrun(clr_overrun), .clr_timeout(clr_timeout),
`ifdef UART_RX_CTRL_ERR_DROP_EN
    .err_drop(err_drop),
`endif
    .irq(irq)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [9:0] exp_q[$];
  logic [9:0] mon_e;
  bit [1:0]   mdl_pend;
  bit         mdl_ovr, mdl_to, mdl_irq, mdl_edrop;
  int         bit_ph, idle;
  bit         accepting, chk_on;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: status every cycle, scoreboard pop on each delivered character.
  always @(negedge clk) begin
    if (chk_on) begin
      check("m_valid", 32'(m_valid), 32'(exp_q.size() != 0));
      check("level",   32'(level),   32'(exp_q.size()));
      check("overrun", 32'(overrun), 32'(mdl_ovr));
      check("timeout", 32'(timeout), 32'(mdl_to));
      check("irq",     32'(irq),     32'(mdl_irq));
      if (m_valid && m_ready && exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("pop_data", 32'(m_data), 32'(mon_e[7:0]));
        check("pop_err",  32'(m_err),  32'(mon_e[9:8]));
        $display("[TB] pop data=%02h err=%b exp_data=%02h exp_err=%b", m_data, m_err, mon_e[7:0], mon_e[9:8]);
      end
    end
  end

  // One clock of stimulus: snapshot the model inputs, advance the clock,
  // apply the cycle's effects to the reference model, drop one-shot inputs.
  task automatic cyc();
    int       pre_lvl, eff;
    bit       pop_s, push_s, drop, irq_n, bt, to_set, ok_s, edrop_set;
    bit [1:0] merged;
    bit [7:0] d;
    bit       s_flush, s_valid, s_clr_o, s_clr_t, s_tick;
    pre_lvl   = exp_q.size();
    eff       = (osr_value == 8'd0) ? 1 : int'(osr_value);
    pop_s     = m_ready && (pre_lvl > 0);
    push_s    = rx_valid && accepting;
    merged    = mdl_pend | {rx_parity_error, rx_framing_error};
    d         = rx_data;
    s_flush   = flush;
    s_valid   = rx_valid;
    s_clr_o   = clr_overrun;
    s_clr_t   = clr_timeout;
    s_tick    = osr_tick;
`ifdef UART_RX_CTRL_ERR_DROP_EN
    ok_s      = (merged == 2'b00);
`else
    ok_s      = 1'b1;
`endif
    edrop_set = push_s && !ok_s && !s_flush;
    drop      = push_s && ok_s && !s_flush && (pre_lvl == DEPTH) && !pop_s;
    irq_n     = mdl_ovr | mdl_to | mdl_edrop | ((watermark != 0) && (pre_lvl >= int'(watermark)));
    @(posedge clk);
    #1;
    bt = 1'b0;
    if (s_tick) begin
      if (bit_ph >= eff - 1) begin bit_ph = 0; bt = 1'b1; end
      else bit_ph++;
    end
    to_set = 1'b0;
    if (push_s || pop_s || s_flush || pre_lvl == 0) idle = 0;
    else if (bt && idle < TO_BITS) begin
      idle++;
      to_set = (idle == TO_BITS);
    end
    mdl_to    = to_set | (mdl_to & !s_clr_t);
    mdl_irq   = irq_n;
    mdl_ovr   = drop | (mdl_ovr & !s_clr_o);
    mdl_edrop = edrop_set | (mdl_edrop & !s_clr_o);
    if (s_flush) exp_q.delete();
    else if (push_s && ok_s && !drop) exp_q.push_back({merged, d});
    mdl_pend = (s_flush || s_valid) ? 2'b00 : merged;
    rx_valid = 1'b0; rx_parity_error = 1'b0; rx_framing_error = 1'b0;
    flush = 1'b0; clr_overrun = 1'b0; clr_timeout = 1'b0; osr_tick = 1'b0; m_ready = 1'b0;
  endtask

  task automatic push_char(input logic [7:0] c);
    rx_valid = 1'b1;
    rx_data  = c;
    cyc();
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; rx_en_cfg = 1'b0; flush = 1'b0; osr_tick = 1'b0;
    osr_value = 8'd16; rxd_sync = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    rx_framing_error = 1'b0; rx_parity_error = 1'b0; rx_busy = 1'b0; m_ready = 1'b0;
    watermark = '0; clr_overrun = 1'b0; clr_timeout = 1'b0;
    mdl_pend = 2'b00; mdl_ovr = 1'b0; mdl_to = 1'b0; mdl_irq = 1'b0; mdl_edrop = 1'b0;
    bit_ph = 0; idle = 0; accepting = 1'b0; chk_on = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_enable", 32'(rx_enable), 32'd0);
    check("rst_m_valid",   32'(m_valid),   32'd0);
    check("rst_level",     32'(level),     32'd0);
    check("rst_overrun",   32'(overrun),   32'd0);
    check("rst_timeout",   32'(timeout),   32'd0);
    check("rst_irq",       32'(irq),       32'd0);
    check("rst_m_data",    32'({m_err, m_data}), 32'd0);
    rst = 1'b0;
    chk_on = 1'b1;

    // Arming: low line never arms; 16 consecutive high ticks are needed.
    enable = 1'b1; rx_en_cfg = 1'b1; rxd_sync = 1'b0;
    for (int i = 0; i < 20; i++) begin osr_tick = 1'b1; cyc(); end
    check("arm_line_low", 32'(rx_enable), 32'd0);
    rxd_sync = 1'b1;
    for (int i = 0; i < 9; i++) begin osr_tick = 1'b1; cyc(); end
    rxd_sync = 1'b0; osr_tick = 1'b1; cyc();
    rxd_sync = 1'b1;
    for (int i = 0; i < 15; i++) begin osr_tick = 1'b1; cyc(); end
    check("arm_15_ticks", 32'(rx_enable), 32'd0);
    osr_tick = 1'b1; cyc();
    check("arm_16_ticks", 32'(rx_enable), 32'd1);
    accepting = 1'b1;

    // Error merge: parity pulse ahead of its character.
    rx_parity_error = 1'b1; cyc();
    push_char(8'hA5);
    push_char(8'h3C);
`ifndef UART_RX_CTRL_ERR_DROP_EN
    check("merge_head", 32'({m_err, m_data}), 32'h2A5);
    m_ready = 1'b1; cyc();
    check("clean_head", 32'({m_err, m_data}), 32'h03C);
`else
    m_ready = 1'b1; cyc();
`endif
    m_ready = 1'b1; cyc();

    // Full FIFO: 17 characters, no pops.
    for (int i = 0; i < 17; i++) push_char(8'($urandom));
    check("full_level",   32'(level),   32'd16);
    check("full_overrun", 32'(overrun), 32'd1);
    cyc();
    check("full_irq", 32'(irq), 32'd1);
    rx_valid = 1'b1; rx_data = 8'h99; m_ready = 1'b1; cyc();
    check("full_pushpop_level",   32'(level),   32'd16);
    check("full_pushpop_overrun", 32'(overrun), 32'd1);
    clr_overrun = 1'b1; cyc();
    check("clr_overrun", 32'(overrun), 32'd0);
    for (int i = 0; i < 16; i++) begin m_ready = 1'b1; cyc(); end
    check("drained_level", 32'(level), 32'd0);

    // Flush beats a same-cycle push.
    push_char(8'h11);
    flush = 1'b1; rx_valid = 1'b1; rx_data = 8'h55; cyc();
    check("flush_level",   32'(level),   32'd0);
    check("flush_m_valid", 32'(m_valid), 32'd0);
    check("flush_overrun", 32'(overrun), 32'd0);

    // Watermark 2: irq follows level one cycle later.
    watermark = LVLW'(2);
    push_char(8'h01);
    push_char(8'h02);
    check("wm_irq_early", 32'(irq), 32'd0);
    cyc();
    check("wm_irq", 32'(irq), 32'd1);
    watermark = '0;
    for (int i = 0; i < 2; i++) begin m_ready = 1'b1; cyc(); end

    // Timeout: 40 bit-times at osr_value 4 with one character waiting.
    osr_value = 8'd4;
    for (int i = 0; i < 20 && bit_ph != 0; i++) begin osr_tick = 1'b1; cyc(); end
    push_char(8'h77);
    for (int i = 0; i < 159; i++) begin osr_tick = 1'b1; cyc(); end
    check("to_before", 32'(timeout), 32'd0);
    osr_tick = 1'b1; cyc();
    check("to_set", 32'(timeout), 32'd1);
    clr_timeout = 1'b1; m_ready = 1'b1; cyc();
    push_char(8'h78);
    push_char(8'h79);
    for (int i = 0; i < 158; i++) begin osr_tick = 1'b1; cyc(); end
    osr_tick = 1'b1; m_ready = 1'b1; cyc();
    osr_tick = 1'b1; cyc();
    check("to_prevented", 32'(timeout), 32'd0);
    m_ready = 1'b1; cyc();

    // Randomized traffic in RUN, alternating light and heavy back-pressure.
    for (int seg = 0; seg < 4; seg++) begin
      osr_value = 8'($urandom_range(0, 6));
      watermark = LVLW'($urandom_range(0, DEPTH));
      for (int i = 0; i < 400; i++) begin
        rx_valid         = ($urandom_range(0, 2) == 0);
        rx_data          = 8'($urandom);
        rx_parity_error  = ($urandom_range(0, 7) == 0);
        rx_framing_error = ($urandom_range(0, 7) == 0);
        m_ready          = seg[0] ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
        flush            = ($urandom_range(0, 99) == 0);
        clr_overrun      = ($urandom_range(0, 31) == 0);
        clr_timeout      = ($urandom_range(0, 31) == 0);
        osr_tick         = ($urandom_range(0, 1) == 1);
        cyc();
      end
    end
    watermark = '0;

    // Graceful drain: rx_en_cfg drops mid-character.
    flush = 1'b1; clr_overrun = 1'b1; clr_timeout = 1'b1; cyc();
    rx_busy = 1'b1; rx_en_cfg = 1'b0; cyc();
    check("drain_hold", 32'(rx_enable), 32'd1);
    cyc(); cyc(); cyc();
    check("drain_hold_late", 32'(rx_enable), 32'd1);
    push_char(8'h41);
    check("drain_off",  32'(rx_enable), 32'd0);
    check("drain_char", 32'({m_err, m_data}), 32'h041);
    accepting = 1'b0; mdl_pend = 2'b00; rx_busy = 1'b0;

    // Re-arm at osr_value 2, then drop the global enable.
    rx_en_cfg = 1'b1; rxd_sync = 1'b1; osr_value = 8'd2; cyc();
    osr_tick = 1'b1; cyc();
    osr_tick = 1'b1; cyc();
    check("rearm", 32'(rx_enable), 32'd1);
    accepting = 1'b1;
    enable = 1'b0; cyc();
    check("enable_drop", 32'(rx_enable), 32'd0);
    check("retain_level", 32'(level), 32'd1);
    accepting = 1'b0; mdl_pend = 2'b00;
    m_ready = 1'b1; cyc();
    repeat (3) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
